// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the main-memory port for one load/store request
// at a time on behalf of the MEM stage. Byte stores use read-modify-write.
// Load data is returned with optional sign extension over a valid/ready channel.
//
// Ports:
//   clk, rst (async, active-low), halt_sys (freezes the controller)
//   req_*   : request channel (valid/ready), write/byte/signed flags, addr, wdata
//   resp_*  : response channel (valid/ready), rdata, err
//   mem_*   : memory port; mem_data_in is combinational from mem_address
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_sys,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [15:0] mem_address,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_data_in
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic            byte_q, byte_d;
    logic            signed_q, signed_d;
    logic [BW-1:0]   wbyte_q, wbyte_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            mem_wen_q, mem_wen_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic            accept;
    logic            word_wrap;
    logic [DW-1:0]   load_data;

    // Request handshake and halt gating of the write strobe
    assign req_ready      = (state_q == S_IDLE) && !halt_sys;
    assign accept         = req_valid && req_ready;
    assign mem_write_en   = mem_wen_q && !halt_sys;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;

    // A word at the top address would straddle the end of the address space
    assign word_wrap = !req_byte && (req_addr == {AW{1'b1}});

    // Load result formed from the current read data
    assign load_data = byte_q
        ? {{(DW-BW){mem_data_in[BW-1] & signed_q}}, mem_data_in[BW-1:0]}
        : mem_data_in;

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        byte_d       = byte_q;
        signed_d     = signed_q;
        wbyte_d      = wbyte_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wen_d    = mem_wen_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        if (!halt_sys) begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        write_d  = req_write;
                        byte_d   = req_byte;
                        signed_d = req_signed;
                        wbyte_d  = req_wdata[BW-1:0];
                        if (word_wrap) begin
                            state_d      = S_RESP;
                            resp_valid_d = 1'b1;
                            resp_rdata_d = '0;
                            resp_err_d   = 1'b1;
                        end else if (!req_write || req_byte) begin
                            state_d    = S_RD;
                            mem_addr_d = req_addr;
                        end else begin
                            state_d     = S_WR;
                            mem_addr_d  = req_addr;
                            mem_wen_d   = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (write_q) begin
                        // Merge: keep the upper byte, replace the addressed byte
                        state_d     = S_WR;
                        mem_wen_d   = 1'b1;
                        mem_wdata_d = {mem_data_in[DW-1:BW], wbyte_q};
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                        resp_err_d   = 1'b0;
                    end
                end
                S_WR: begin
                    state_d      = S_RESP;
                    mem_wen_d    = 1'b0;
                    mem_wdata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b0;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            wbyte_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            signed_q     <= signed_d;
            wbyte_q      <= wbyte_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wen_q    <= mem_wen_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-addressed memory model, shadow reference
// memory, directed scenarios followed by randomized transactions.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_data_in;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] mem_a1;
    logic        mem_load;
    logic [7:0]  seed;
    int          wen_count;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    mem_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .halt_sys       (halt_sys),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_data_in    (mem_data_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i, input logic [7:0] s);
        return 8'((i * 91) ^ (i >> 8) ^ int'(s));
    endfunction

    // Memory: combinational read, word-wide write on the strobe
    assign mem_a1      = mem_address + 16'd1;
    assign mem_data_in = {mem[mem_a1], mem[mem_address]};

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(i, seed);
            wen_count <= 0;
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_write_data[7:0];
            mem[mem_a1]      <= mem_write_data[15:8];
            wen_count        <= wen_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // One full transaction: compute expectation from the shadow memory, drive,
    // follow the cycle-by-cycle port behaviour, then complete the response.
    task automatic txn(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] d,
                       input int rdy_dly, input int halt_at);
        logic [15:0] a1, exp_rd, exp_wd;
        logic        exp_err, hit;
        int          lat, wr_cyc, n, wcnt0;
        a1 = a + 16'd1;
        exp_rd = 16'h0000; exp_wd = 16'h0000; exp_err = 1'b0; wr_cyc = 0;
        if (!b && a == 16'hFFFF) begin
            exp_err = 1'b1; lat = 1;
        end else if (!w) begin
            lat = 2;
            if (b) begin
                exp_rd = {8'h00, ref_mem[a]};
                if (s && ref_mem[a] >= 8'h80) exp_rd = exp_rd + 16'hFF00;
            end else begin
                exp_rd = ref_mem[a1] * 256 + ref_mem[a];
            end
        end else if (!b) begin
            lat = 2; wr_cyc = 1; exp_wd = d;
        end else begin
            lat = 3; wr_cyc = 2; exp_wd = {ref_mem[a1], d[7:0]};
        end
        if (wr_cyc != 0) begin
            ref_mem[a]  = exp_wd[7:0];
            ref_mem[a1] = exp_wd[15:8];
        end

        chk("req_ready_idle", 16'(req_ready), 16'd1);
        wcnt0      = wen_count;
        req_valid  = 1'b1;
        req_write  = w;
        req_byte   = b;
        req_signed = s;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b0;
        @(posedge clk);
        n = 0; hit = 1'b0;
        while (!hit && n <= 20) begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (n == halt_at) begin
                halt_sys = 1'b1;
                repeat (4) begin
                    #1;
                    chk("halt_wen", 16'(mem_write_en), 16'd0);
                    chk("halt_ready", 16'(req_ready), 16'd0);
                    @(negedge clk);
                end
                halt_sys = 1'b0;
            end
            #1;
            if (n == wr_cyc) begin
                chk("wr_en", 16'(mem_write_en), 16'd1);
                chk("wr_data", mem_write_data, exp_wd);
            end else begin
                chk("idle_wen", 16'(mem_write_en), 16'd0);
                chk("idle_wdata", mem_write_data, 16'h0000);
            end
            if (n < lat) chk("mem_addr", mem_address, a);
            hit = resp_valid;
        end
        chk("latency", 16'(n), 16'(lat));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 16'(resp_err), 16'(exp_err));
        repeat (rdy_dly) begin
            @(negedge clk);
            chk("hold_valid", 16'(resp_valid), 16'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", 16'(resp_err), 16'(exp_err));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", 16'(resp_valid), 16'd0);
        chk("write_count", 16'(wen_count - wcnt0), 16'(wr_cyc != 0));
        chk("mem_word", {mem[a1], mem[a]}, {ref_mem[a1], ref_mem[a]});
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        seed = 8'($urandom);
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i, seed);
        mem_load   = 1'b1;
        rst        = 1'b0;
        halt_sys   = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        mem_load = 1'b0;
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_valid", 16'(resp_valid), 16'd0);
        chk("rst_rdata", resp_rdata, 16'h0000);
        chk("rst_err", 16'(resp_err), 16'd0);
        chk("rst_wen", 16'(mem_write_en), 16'd0);
        chk("rst_addr", mem_address, 16'h0000);
        chk("rst_wdata", mem_write_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Word store / load round trip
        txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 0, 0);
        txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0);
        // Byte loads with and without sign extension
        txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1280, 0, 0);
        txn(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 0, 0);
        txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, 0);
        txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0);
        // Byte store merges into the existing word
        txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'hA55A, 0, 0);
        txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0);
        txn(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 0, 0);
        // Word accesses at the top address are rejected
        txn(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
        txn(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 0, 0);
        // Halt during the write cycle, then slow response consumer
        txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'hCAFE, 3, 1);
        txn(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0033, 2, 2);

        // Reset during the write cycle of a byte store
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0030; req_wdata = 16'h0077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rstwr_wen_before", 16'(mem_write_en), 16'd1);
        rst = 1'b0;
        #1;
        chk("rstwr_wen", 16'(mem_write_en), 16'd0);
        chk("rstwr_valid", 16'(resp_valid), 16'd0);
        chk("rstwr_ready", 16'(req_ready), 16'd1);
        chk("rstwr_addr", mem_address, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_mem", {mem[16'h0031], mem[16'h0030]}, {ref_mem[16'h0031], ref_mem[16'h0030]});

        // Randomized transactions
        for (int k = 0; k < 150; k++) begin
            logic [15:0] ra;
            int          sel, hat;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      ra = 16'hFFFF;
            else if (sel == 1) ra = 16'hFFFE;
            else               ra = 16'($urandom_range(0, 31));
            hat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom),
                int'($urandom_range(0, 2)), hat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
